// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter and its input conditioning.
package period_meter_pkg;

   localparam int CNT_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      ST_ARM   = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } state_e;

endpackage

// File: rtl/period_meter_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with rise/fall detection
// on the synchronized level.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_s,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], i_d};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign o_s    = sync_q[STAGES-1];
   assign o_rise = o_s & ~prev_q;
   assign o_fall = ~o_s & prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures period (rise to rise) and high time of a slow asynchronous input in
// i_clk cycles; one-cycle o_valid per measurement, sticky o_timeout on stall.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_sig,
   output logic [CNT_WIDTH-1:0] o_period,
   output logic [CNT_WIDTH-1:0] o_high,
   output logic                 o_valid,
   output logic                 o_timeout
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic s, rise, fall_unused;

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_d    (i_sig),
      .o_s    (s),
      .o_rise (rise),
      .o_fall (fall_unused)
   );

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
   logic [CNT_WIDTH-1:0] period_q, period_d, high_q, high_d;
   logic                 valid_q, valid_d, timeout_q, timeout_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hcnt_d    = hcnt_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
      case (state_q)
         ST_ARM: begin
            cnt_d  = '0;
            hcnt_d = '0;
            if (rise) begin
               cnt_d   = CNT_ONE;
               hcnt_d  = CNT_ONE;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // A rise wins over saturation, so a period of exactly MAX is valid.
            if (rise) begin
               period_d  = cnt_q;
               high_d    = hcnt_q;
               valid_d   = 1'b1;
               timeout_d = 1'b0;
               cnt_d     = CNT_ONE;
               hcnt_d    = CNT_ONE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
               if (s && hcnt_q != CNT_MAX) hcnt_d = hcnt_q + CNT_ONE;
            end else begin
               state_d   = ST_STALL;
               timeout_d = 1'b1;
            end
         end
         ST_STALL: begin
            if (rise) begin
               cnt_d   = CNT_ONE;
               hcnt_d  = CNT_ONE;
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_ARM;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_ARM;
         cnt_q     <= '0;
         hcnt_q    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hcnt_q    <= hcnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_period  = period_q;
   assign o_high    = high_q;
   assign o_valid   = valid_q;
   assign o_timeout = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Two meters (16-bit and 8-bit counters) share one random pulse stream; a
// rise-time reference model queues expected events, monitors pop and compare.
module tb_period_meter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sig = 1'b0;
   logic [15:0] p16, h16;
   logic [7:0]  p8, h8;
   logic        v16, t16, v8, t8;
   logic        pt16 = 1'b0, pt8 = 1'b0;
   int          cyc = 0;
   int          n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   period_meter #(.CNT_WIDTH(16), .SYNC_STAGES(2)) dut16 (
      .i_clk(clk), .i_rst(rst), .i_sig(sig),
      .o_period(p16), .o_high(h16), .o_valid(v16), .o_timeout(t16));

   period_meter #(.CNT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
      .i_clk(clk), .i_rst(rst), .i_sig(sig),
      .o_period(p8), .o_high(h8), .o_valid(v8), .o_timeout(t8));

   typedef struct {
      bit to;
      int cyc;
      int per;
      int hi;
   } ev_t;

   ev_t q0[$];
   ev_t q1[$];

   // Reference model state per instance: measuring flag, last rise time, its
   // high length, last reported values and the expected timeout level.
   int mx[2]  = '{65535, 255};
   int st[2]  = '{0, 0};
   int ra[2]  = '{0, 0};
   int hh[2]  = '{0, 0};
   int lp[2]  = '{0, 0};
   int lh[2]  = '{0, 0};
   int tol[2] = '{0, 0};

   localparam int LAT = 3;  // two sync flops plus the registered output

   task automatic chk(string nm, int got, int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s got=%0d expected=%0d (cycle %0d)", nm, got, exp, cyc);
   endtask

   task automatic push(int i, ev_t e);
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic model_rise(int i, int t, int h, int l, bit to_ok);
      ev_t e;
      int  p;
      if (st[i] != 0) begin
         p = t - ra[i];
         if (p <= mx[i]) begin
            e.to = 1'b0; e.cyc = t + LAT; e.per = p; e.hi = hh[i];
            push(i, e);
            lp[i] = p; lh[i] = hh[i]; tol[i] = 0;
         end
      end
      st[i] = 1; ra[i] = t; hh[i] = h;
      if (to_ok && (h + l > mx[i]) && tol[i] == 0) begin
         e.to = 1'b1; e.cyc = t + LAT + mx[i]; e.per = lp[i]; e.hi = lh[i];
         push(i, e);
         tol[i] = 1;
      end
   endtask

   task automatic mon(int i, bit v, bit to, bit pto, int per, int hi);
      ev_t   e;
      string n;
      n = (i == 0) ? "w16" : "w8";
      if (v || (to && !pto)) begin
         if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            chk({n, "_spurious_event"}, 1, 0);
         end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk({n, "_kind_is_timeout"}, int'(!v), int'(e.to));
            chk({n, "_cycle"}, cyc, e.cyc);
            chk({n, "_period"}, per, e.per);
            chk({n, "_high"}, hi, e.hi);
            chk({n, "_timeout"}, int'(to), int'(e.to));
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, v16, t16, pt16, int'(p16), int'(h16));
      mon(1, v8, t8, pt8, int'(p8), int'(h8));
      pt16 = t16;
      pt8  = t8;
   end

   task automatic check_zero(string tag);
      chk({tag, "_w16_period"}, int'(p16), 0);
      chk({tag, "_w16_high"}, int'(h16), 0);
      chk({tag, "_w16_valid"}, int'(v16), 0);
      chk({tag, "_w16_timeout"}, int'(t16), 0);
      chk({tag, "_w8_period"}, int'(p8), 0);
      chk({tag, "_w8_high"}, int'(h8), 0);
      chk({tag, "_w8_valid"}, int'(v8), 0);
      chk({tag, "_w8_timeout"}, int'(t8), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_zero("midrst");
      chk("midrst_q16_drained", q0.size(), 0);
      chk("midrst_q8_drained", q1.size(), 0);
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
         st[i] = 0; lp[i] = 0; lh[i] = 0; tol[i] = 0;
      end
   endtask

   // One rise, h cycles high, l cycles low; optional reset rst_at cycles into the low phase.
   task automatic pulse(int h, int l, int rst_at);
      int t;
      t = cyc;
      model_rise(0, t, h, l, rst_at == 0);
      model_rise(1, t, h, l, rst_at == 0);
      sig = 1'b1;
      repeat (h) @(negedge clk);
      sig = 1'b0;
      for (int k = 0; k < l; k++) begin
         if (rst_at != 0 && k == rst_at) do_reset();
         else @(negedge clk);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_zero("reset");

      for (int k = 0; k < 4; k++) pulse(512, 512, 0);
      pulse(3, 10, 5);
      for (int k = 0; k < 4; k++) pulse(5, 7, 0);
      pulse(4, 296, 0);
      pulse(3, 7, 0);
      pulse(3, 7, 0);
      pulse(5, 250, 0);
      pulse(5, 251, 0);
      pulse(400, 10, 0);
      pulse(3, 7, 0);
      for (int k = 0; k < 30; k++) begin
         int h, l;
         h = $urandom_range(1, 40);
         l = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 300) : $urandom_range(1, 120);
         pulse(h, l, 0);
      end
      pulse(2, 300, 0);
      repeat (5) @(negedge clk);
      chk("end_q16_drained", q0.size(), 0);
      chk("end_q8_drained", q1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
